core_host_ctl: RTL
==================

# core_host_ctl

Host-side initiator for the processor core's `req`/`done` run handshake. It preloads the core's data memory through a back-door write port and holds the core in reset for a guaranteed window. It then asserts the run request, counts execution cycles until the core raises `done`, and reports completion or timeout. It sits between the test/host harness and the core's top level.

## Interface
Parameters:
- `AW`, 8, data-memory address width
- `DW`, 8, data-memory word width
- `CW`, 16, cycle-counter width; must hold `TIMEOUT`
- `TIMEOUT`, 4096, maximum RUN cycles before abort
- `RST_CYC`, 2, minimum core-reset cycles before RUN (≥1)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; all state cleared while low
- `start`  in  1  one-cycle request to launch a run
- `abort`  in  1  force return to IDLE
- `load_valid`  in  1  preload beat valid
- `load_ready`  out  1  preload beat accepted when `load_valid & load_ready`
- `load_addr`  in  AW  preload address
- `load_dat`  in  DW  preload data
- `mem_wr_en`  out  1  data-memory back-door write enable
- `mem_addr`  out  AW  write address
- `mem_dat`  out  DW  write data
- `core_reset`  out  1  core reset, active-high
- `core_req`  out  1  core run request
- `core_done`  in  1  core completion flag, combinational from core
- `busy`  out  1  RESET_CORE or RUN
- `finished`  out  1  last run ended with `core_done`
- `timed_out`  out  1  last run hit `TIMEOUT`
- `cycles`  out  CW  RUN cycles of last run

## Operation
- States: IDLE, RESET_CORE, RUN, DONE, TIMEOUT. Reset enters IDLE.
- All outputs except `load_ready` are registered (Moore). `load_ready` = 1 in IDLE, DONE and TIMEOUT, and 0 otherwise.
- Preload:
  - An accepted beat drives `mem_wr_en`=1 with the captured `mem_addr`/`mem_dat` on the next cycle only.
  - Back-to-back beats give one write per cycle.
- `core_reset`=1 in every state except RUN. `core_req`=1 only in RUN.
- Launching from IDLE, DONE or TIMEOUT: `start` goes to RESET_CORE and clears `finished`, `timed_out` and `cycles`.
- RESET_CORE lasts exactly `RST_CYC` cycles, then moves to RUN.
- RUN: `cycles` increments every RUN cycle, including the one in which `core_done` is sampled high.
  - `core_done`=1 goes to DONE with `finished`=1.
  - Otherwise, reaching `cycles`=`TIMEOUT` goes to TIMEOUT with `timed_out`=1.
  - If `core_done` arrives on the same cycle the limit is reached, DONE wins.
- DONE/TIMEOUT: status and `cycles` are held until the next `start` or `abort`.
- `abort` (any state): goes to IDLE next cycle and clears status and `cycles`. `abort` has priority over `start`.
- `start` during RESET_CORE/RUN is ignored.
- `start` and an accepted load beat in the same cycle: both take effect. The write issues in the first RESET_CORE cycle.
- `core_done` outside RUN is ignored.

## Timing
- Reset values: `core_reset`=1, `core_req`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_dat`=0, `busy`=0, `finished`=0, `timed_out`=0, `cycles`=0, `load_ready`=1.
- `start` sampled at edge t:
  - `busy`=1 and RESET_CORE for cycles t+1 … t+`RST_CYC`.
  - `core_req`=1 and `core_reset`=0 from t+`RST_CYC`+1.
- `core_done` sampled high at edge r in RUN: at r+1, `core_req`=0, `core_reset`=1, `busy`=0, `finished`=1, `cycles`=final count.
- Timeout: TIMEOUT is entered one cycle after the `TIMEOUT`th RUN cycle, with `cycles`=`TIMEOUT`.
- Preload write latency: 1 cycle, no throughput loss.
- Asynchronous reset mid-run forces the reset values immediately, with no wait for a clock edge.

## Test plan
- Reset, then preload addr 0x10/0x11 with 0x5A/0xA5 back-to-back → `mem_wr_en` high for 2 consecutive cycles with matching addr/dat, `load_ready` stays 1.
- `start` with `RST_CYC`=2, core model raises `core_done` on the 100th RUN cycle → `core_reset` low for exactly 100 cycles, `finished`=1, `cycles`=100, `core_req` drops the next cycle.
- `TIMEOUT`=16, `core_done` never raised → `timed_out`=1, `finished`=0, `cycles`=16, `core_reset`=1.
- `core_done` raised on exactly the 16th RUN cycle with `TIMEOUT`=16 → DONE, `finished`=1, `timed_out`=0, `cycles`=16.
- `abort` mid-RUN at `cycles`=40 → IDLE next cycle, `core_req`=0, `cycles`=0; `start` during RUN ignored, and `start` from DONE reruns with status cleared.
- Drop `reset` low mid-RUN → all outputs at reset values asynchronously; after release the block is in IDLE with `load_ready`=1.

Source files
------------

// File: rtl/core_host_ctl.sv
`default_nettype none
// ==== core_host_ctl : host-side run initiator (preload, core reset window, run/timeout) ====
// ==== rev 1.0 ====
module core_host_ctl #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int CW      = 16,
  parameter int TIMEOUT = 4096,
  parameter int RST_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_dat,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          busy,
  output logic          finished,
  output logic          timed_out,
  output logic [CW-1:0] cycles
);

  localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYC - 1);
  localparam logic [CW-1:0]  CYC_LIMIT = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RESET_CORE = 3'd1,
    S_RUN        = 3'd2,
    S_DONE       = 3'd3,
    S_TIMEOUT    = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [RCW-1:0] r_rst_cnt;
  logic [CW-1:0]  r_cycles;
  logic [CW-1:0]  w_cyc_inc;
  logic           w_ready;
  logic           w_launch;
  logic           w_hit_limit;
  logic           r_mem_wr_en;
  logic [AW-1:0]  r_mem_addr;
  logic [DW-1:0]  r_mem_dat;
  logic           r_core_reset;
  logic           r_core_req;
  logic           r_busy;
  logic           r_finished;
  logic           r_timed_out;

  assign w_ready     = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_TIMEOUT);
  assign w_launch    = !abort && start && w_ready;
  assign w_cyc_inc   = r_cycles + 1'b1;
  assign w_hit_limit = (w_cyc_inc == CYC_LIMIT);

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_TIMEOUT: if (start) w_next = S_RESET_CORE;
        S_RESET_CORE:              if (r_rst_cnt == RST_LAST) w_next = S_RUN;
        S_RUN: begin
          // Completion takes precedence over hitting the cycle limit.
          if (core_done)        w_next = S_DONE;
          else if (w_hit_limit) w_next = S_TIMEOUT;
        end
        default:                   w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_rst_cnt    <= '0;
      r_cycles     <= '0;
      r_mem_wr_en  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_dat    <= '0;
      r_core_reset <= 1'b1;
      r_core_req   <= 1'b0;
      r_busy       <= 1'b0;
      r_finished   <= 1'b0;
      r_timed_out  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_rst_cnt    <= (r_state == S_RESET_CORE && w_next == S_RESET_CORE) ? r_rst_cnt + 1'b1 : '0;
      r_core_reset <= (w_next != S_RUN);
      r_core_req   <= (w_next == S_RUN);
      r_busy       <= (w_next == S_RESET_CORE) || (w_next == S_RUN);

      if (abort || w_launch) begin
        r_cycles    <= '0;
        r_finished  <= 1'b0;
        r_timed_out <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_cycles    <= w_cyc_inc;
        r_finished  <= core_done;
        r_timed_out <= !core_done && w_hit_limit;
      end

      r_mem_wr_en <= load_valid && w_ready;
      if (load_valid && w_ready) begin
        r_mem_addr <= load_addr;
        r_mem_dat  <= load_dat;
      end
    end
  end

  assign load_ready = w_ready;
  assign mem_wr_en  = r_mem_wr_en;
  assign mem_addr   = r_mem_addr;
  assign mem_dat    = r_mem_dat;
  assign core_reset = r_core_reset;
  assign core_req   = r_core_req;
  assign busy       = r_busy;
  assign finished   = r_finished;
  assign timed_out  = r_timed_out;
  assign cycles     = r_cycles;

endmodule
`default_nettype wire
